// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants: machine widths, the reset PC,
// the fetch FSM states and the {pc, inst} entry held by the prefetch FIFO.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_fifo.sv
// Synchronous FIFO of fetch entries with a registered head and single-cycle
// flush; flush wins over a same-cycle push or pop.
module if_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  fetch_entry_t           entry_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output fetch_entry_t           head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW-1:0] PTR_ZERO  = AW'(0);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_ZERO  = (AW+1)'(0);
  localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push_s, do_pop_s;

  assign full_o    = (count_q == CNT_DEPTH);
  assign empty_o   = (count_q == CNT_ZERO);
  assign count_o   = count_q;
  assign head_o    = mem_q[rd_ptr_q];
  assign do_pop_s  = pop_i && !empty_o;
  assign do_push_s = push_i && (!full_o || do_pop_s);

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = PTR_ZERO;
      rd_ptr_d = PTR_ZERO;
      count_d  = CNT_ZERO;
    end else begin
      if (do_push_s) begin
        mem_d[wr_ptr_q] = entry_i;
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (do_push_s && !do_pop_s) begin
        count_d = count_q + CNT_ONE;
      end else if (!do_push_s && do_pop_s) begin
        count_d = count_q - CNT_ONE;
      end else begin
        count_d = count_q;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {$bits(fetch_entry_t){1'b0}};
      end
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      count_q  <= CNT_ZERO;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/if_prefetch_chk.sv
// Protocol checks for the prefetch stage: no push into a full FIFO, no
// orphan responses, and only word-aligned fetch addresses.
module if_prefetch_chk #(
  parameter int CW = 3
) (
  input logic          clk,
  input logic          rst_n,
  input logic          push_i,
  input logic          pop_i,
  input logic          full_i,
  input logic          rvalid_i,
  input logic [CW-1:0] outstanding_i,
  input logic [CW-1:0] discard_i,
  input logic          req_i,
  input logic [1:0]    addr_lsb_i
);

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && full_i && !pop_i));

  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
    !(rvalid_i && (outstanding_i == {CW{1'b0}}) && (discard_i == {CW{1'b0}})));

  a_addr_aligned: assert property (@(posedge clk) disable iff (!rst_n)
    !(req_i && (addr_lsb_i != 2'b00)));

endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetch stage: credit-limited word fetches into a small FIFO,
// valid/ready delivery to decode, and flush/discard on redirect.
module if_prefetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 4,
  parameter int              MAX_OUT  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [ILEN-1:0] imem_rdata_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [ILEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_pc_o,
  output logic [XLEN-1:0] inst_pc4_o,
  output logic            fetch_err_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUT);
  localparam logic [CW:0]   DEPTH_C   = (CW+1)'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] ret_pc_q, ret_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic            err_q, err_d;

  fetch_entry_t    head_s, push_entry_s;
  logic [CW-1:0]   fifo_count_s, inflight_s;
  logic [CW:0]     credit_s;
  logic            fifo_full_s, fifo_empty_s;
  logic            pop_s, push_s, gnt_fire_s, redir_s, misalign_s;
  logic            rv_live_s, rv_dead_s;

  assign inst_valid_o = !fifo_empty_s && (state_q != HALT);
  assign pop_s        = inst_valid_o && inst_ready_i;
  assign inflight_s   = outstanding_q + discard_q;
  // FIFO slots already promised: buffered plus live in flight, less this cycle's pop.
  assign credit_s     = {1'b0, fifo_count_s} + {1'b0, outstanding_q} - {{CW{1'b0}}, pop_s};
  assign imem_req_o   = (state_q == RUN) && (inflight_s < MAX_OUT_C) && (credit_s < DEPTH_C);
  assign imem_addr_o  = fetch_pc_q;
  assign gnt_fire_s   = imem_req_o && imem_gnt_i;
  assign rv_dead_s    = imem_rvalid_i && (discard_q != CNT_ZERO);
  assign rv_live_s    = imem_rvalid_i && (discard_q == CNT_ZERO) && (outstanding_q != CNT_ZERO);
  assign redir_s      = redirect_i && (state_q != HALT);
  assign misalign_s   = (redirect_pc_i[1:0] != 2'b00);
  assign push_s       = rv_live_s && !redir_s;
  assign push_entry_s = '{pc: ret_pc_q, inst: imem_rdata_i};

  assign inst_o      = inst_valid_o ? head_s.inst : {ILEN{1'b0}};
  assign inst_pc_o   = inst_valid_o ? head_s.pc : {XLEN{1'b0}};
  assign inst_pc4_o  = inst_valid_o ? (head_s.pc + PC_STEP) : {XLEN{1'b0}};
  assign fetch_err_o = err_q;

  if_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_s),
    .entry_i (push_entry_s),
    .pop_i   (pop_s),
    .flush_i (redir_s),
    .head_o  (head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_s)
  );

  if_prefetch_chk #(
    .CW (CW)
  ) u_chk (
    .clk           (clk),
    .rst_n         (rst_n),
    .push_i        (push_s),
    .pop_i         (pop_s),
    .full_i        (fifo_full_s),
    .rvalid_i      (imem_rvalid_i),
    .outstanding_i (outstanding_q),
    .discard_i     (discard_q),
    .req_i         (imem_req_o),
    .addr_lsb_i    (imem_addr_o[1:0])
  );

  // Next-state for FSM, fetch/return PCs and in-flight bookkeeping.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    ret_pc_d      = ret_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    err_d         = err_q || (redir_s && misalign_s);

    case (state_q)
      BOOT:    state_d = (redir_s && misalign_s) ? HALT : RUN;
      RUN:     state_d = (redir_s && misalign_s) ? HALT : RUN;
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase

    // Every request in flight at a redirect becomes a response to drop.
    if (redir_s) begin
      outstanding_d = CNT_ZERO;
      discard_d     = discard_q + outstanding_q + {{(CW-1){1'b0}}, gnt_fire_s}
                      - {{(CW-1){1'b0}}, (rv_live_s || rv_dead_s)};
    end else begin
      outstanding_d = outstanding_q + {{(CW-1){1'b0}}, gnt_fire_s}
                      - {{(CW-1){1'b0}}, rv_live_s};
      discard_d     = discard_q - {{(CW-1){1'b0}}, rv_dead_s};
    end

    if (redir_s && !misalign_s) begin
      fetch_pc_d = redirect_pc_i;
      ret_pc_d   = redirect_pc_i;
    end else begin
      fetch_pc_d = gnt_fire_s ? (fetch_pc_q + PC_STEP) : fetch_pc_q;
      ret_pc_d   = push_s ? (ret_pc_q + PC_STEP) : ret_pc_q;
    end
  end

  // FSM and bookkeeping registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      fetch_pc_q    <= RESET_PC;
      ret_pc_q      <= RESET_PC;
      outstanding_q <= CNT_ZERO;
      discard_q     <= CNT_ZERO;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      ret_pc_q      <= ret_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      err_q         <= err_d;
    end
  end

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch: an in-order memory responder with
// programmable latency and grant stall, plus a decode-side handshake log.
module tb_if_prefetch;

  localparam logic [31:0] KEY = 32'hDEAD_0000;

  logic        clk;
  logic        rst_n;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic [31:0] inst_pc4_o;
  logic        fetch_err_o;

  int checks;
  int errors;
  int cyc;
  int lat;
  int gnt_delay;
  int wait_cnt;
  logic [31:0] delay_addr;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] gnt_log[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_inst[$];
  logic [31:0] got_pc4[$];
  int          got_cyc[$];

  if_prefetch #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (4),
    .MAX_OUT  (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .inst_valid_o  (inst_valid_o),
    .inst_ready_i  (inst_ready_i),
    .inst_o        (inst_o),
    .inst_pc_o     (inst_pc_o),
    .inst_pc4_o    (inst_pc4_o),
    .fetch_err_o   (fetch_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // Memory: in-order responses lat cycles after grant; grant of delay_addr stalls gnt_delay cycles.
  initial begin
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0; wait_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0; wait_cnt = 0;
        pend_addr.delete(); pend_due.delete();
      end else begin
        if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
          imem_rvalid_i = 1'b1;
          imem_rdata_i  = pend_addr[0] ^ KEY;
          void'(pend_addr.pop_front());
          void'(pend_due.pop_front());
        end else begin
          imem_rvalid_i = 1'b0;
          imem_rdata_i  = 32'h0;
        end
        if (imem_req_o) begin
          if (imem_addr_o == delay_addr && wait_cnt < gnt_delay) begin
            imem_gnt_i = 1'b0;
            wait_cnt   = wait_cnt + 1;
          end else begin
            imem_gnt_i = 1'b1;
            wait_cnt   = 0;
            pend_addr.push_back(imem_addr_o);
            pend_due.push_back(cyc + lat);
            gnt_log.push_back(imem_addr_o);
          end
        end else begin
          imem_gnt_i = 1'b0;
          wait_cnt   = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && inst_valid_o && inst_ready_i) begin
        got_pc.push_back(inst_pc_o);
        got_inst.push_back(inst_o);
        got_pc4.push_back(inst_pc4_o);
        got_cyc.push_back(cyc);
      end
    end
  end

  task automatic apply_reset();
    rst_n = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0; inst_ready_i = 1'b0;
    lat = 1; gnt_delay = 0; delay_addr = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    gnt_log.delete(); got_pc.delete(); got_inst.delete(); got_pc4.delete(); got_cyc.delete();
  endtask

  task automatic reset_dut();
    apply_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b expected 0", imem_req_o); end
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", inst_valid_o); end
    checks++; if (fetch_err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", fetch_err_o); end
    checks++; if (inst_o !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h expected 00000000", inst_o); end
    checks++; if (inst_pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 00000000", inst_pc_o); end
    checks++; if (inst_pc4_o !== 32'h0) begin errors++; $display("FAIL reset_pc4: got %h expected 00000000", inst_pc4_o); end
    rst_n = 1'b1;
    #1;
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL boot_no_req: got %0b expected 0", imem_req_o); end
    @(posedge clk); #1;
    checks++; if (imem_req_o !== 1'b1) begin errors++; $display("FAIL first_req: got %0b expected 1", imem_req_o); end
    checks++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL first_addr: got %h expected 00000000", imem_addr_o); end
  endtask

  task automatic test_back_to_back();
    reset_dut();
    inst_ready_i = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    checks++; if (got_pc.size() < 4) begin errors++; $display("FAIL b2b_count: got %0d expected >=4", got_pc.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= got_pc.size() || got_pc[i] !== 32'(i * 4) || got_inst[i] !== (32'(i * 4) ^ KEY)
          || got_pc4[i] !== 32'(i * 4 + 4)) begin
        errors++;
        $display("FAIL b2b_entry%0d: got pc %h inst %h pc4 %h expected pc %h", i,
                 (i < got_pc.size()) ? got_pc[i] : 32'hX, (i < got_inst.size()) ? got_inst[i] : 32'hX,
                 (i < got_pc4.size()) ? got_pc4[i] : 32'hX, 32'(i * 4));
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i + 1 >= got_cyc.size() || got_cyc[i + 1] - got_cyc[i] !== 1) begin
        errors++;
        $display("FAIL b2b_gap%0d: got gap %0d expected 1", i,
                 (i + 1 < got_cyc.size()) ? got_cyc[i + 1] - got_cyc[i] : -1);
      end
    end
  endtask

  task automatic test_backpressure();
    reset_dut();
    inst_ready_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (gnt_log.size() !== 4) begin errors++; $display("FAIL bp_grants: got %0d expected 4", gnt_log.size()); end
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL bp_req_drop: got %0b expected 0", imem_req_o); end
    checks++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'h0) begin errors++; $display("FAIL bp_head: got valid %0b pc %h expected 1 00000000", inst_valid_o, inst_pc_o); end
    inst_ready_i = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= got_pc.size() || got_pc[i] !== 32'(i * 4) || got_inst[i] !== (32'(i * 4) ^ KEY)) begin
        errors++;
        $display("FAIL bp_drain%0d: got pc %h expected %h", i,
                 (i < got_pc.size()) ? got_pc[i] : 32'hX, 32'(i * 4));
      end
    end
  endtask

  task automatic test_gnt_delay();
    logic [31:0] req_log[$];
    logic [31:0] exp_req [7];
    logic [31:0] exp_gnt [4];
    exp_req = '{32'h0, 32'h4, 32'h8, 32'h8, 32'h8, 32'h8, 32'hC};
    exp_gnt = '{32'h0, 32'h4, 32'h8, 32'hC};
    reset_dut();
    inst_ready_i = 1'b1;
    delay_addr   = 32'h8;
    gnt_delay    = 3;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #2;
      if (imem_req_o) req_log.push_back(imem_addr_o);
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (i >= req_log.size() || req_log[i] !== exp_req[i]) begin
        errors++;
        $display("FAIL gd_addr%0d: got %h expected %h", i, (i < req_log.size()) ? req_log[i] : 32'hX, exp_req[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= gnt_log.size() || gnt_log[i] !== exp_gnt[i] || i >= got_pc.size() || got_pc[i] !== exp_gnt[i]) begin
        errors++;
        $display("FAIL gd_fetch%0d: got gnt %h pc %h expected %h", i, (i < gnt_log.size()) ? gnt_log[i] : 32'hX,
                 (i < got_pc.size()) ? got_pc[i] : 32'hX, exp_gnt[i]);
      end
    end
  endtask

  task automatic test_redirect_flush();
    reset_dut();
    inst_ready_i = 1'b1;
    lat = 3;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL rf_cap: got req %0b expected 0", imem_req_o); end
    redirect_i = 1'b1; redirect_pc_i = 32'h100;
    @(posedge clk); #1;
    redirect_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (got_pc.size() < 1 || got_pc[0] !== 32'h100 || got_pc4[0] !== 32'h104 || got_inst[0] !== (32'h100 ^ KEY)) begin
      errors++;
      $display("FAIL rf_first: got pc %h pc4 %h expected 00000100 00000104",
               (got_pc.size() > 0) ? got_pc[0] : 32'hX, (got_pc4.size() > 0) ? got_pc4[0] : 32'hX);
    end
    checks++;
    if (gnt_log.size() < 3 || gnt_log[2] !== 32'h100) begin
      errors++;
      $display("FAIL rf_refetch: got %h expected 00000100", (gnt_log.size() > 2) ? gnt_log[2] : 32'hX);
    end
  endtask

  task automatic test_redirect_handshake();
    int n4;
    int nold;
    reset_dut();
    inst_ready_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'h4) begin errors++; $display("FAIL rh_head: got valid %0b pc %h expected 1 00000004", inst_valid_o, inst_pc_o); end
    redirect_i = 1'b1; redirect_pc_i = 32'h200;
    @(posedge clk); #1;
    redirect_i = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    n4 = 0; nold = 0;
    foreach (got_pc[i]) begin
      if (got_pc[i] == 32'h4) n4++;
      if (got_pc[i] == 32'h8 || got_pc[i] == 32'hC) nold++;
    end
    checks++; if (n4 !== 1) begin errors++; $display("FAIL rh_once: got %0d expected 1", n4); end
    checks++; if (nold !== 0) begin errors++; $display("FAIL rh_dropped: got %0d expected 0", nold); end
    checks++;
    if (got_pc.size() < 3 || got_pc[0] !== 32'h0 || got_pc[1] !== 32'h4 || got_pc[2] !== 32'h200) begin
      errors++;
      $display("FAIL rh_order: got %h %h %h expected 00000000 00000004 00000200",
               (got_pc.size() > 0) ? got_pc[0] : 32'hX, (got_pc.size() > 1) ? got_pc[1] : 32'hX,
               (got_pc.size() > 2) ? got_pc[2] : 32'hX);
    end
  endtask

  task automatic test_misaligned_and_wrap();
    reset_dut();
    inst_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    redirect_i = 1'b1; redirect_pc_i = 32'h102;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (fetch_err_o !== 1'b1 || imem_req_o !== 1'b0 || inst_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL halt%0d: got err %0b req %0b valid %0b expected 1 0 0", k, fetch_err_o, imem_req_o, inst_valid_o);
      end
      redirect_i    = (k == 1) ? 1'b1 : 1'b0;
      redirect_pc_i = 32'h300;
      @(posedge clk); #1;
    end
    redirect_i = 1'b0;
    apply_reset();
    checks++; if (fetch_err_o !== 1'b0) begin errors++; $display("FAIL halt_clear: got %0b expected 0", fetch_err_o); end
    rst_n = 1'b1;
    inst_ready_i  = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    @(posedge clk); #1;
    redirect_i = 1'b0;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL boot_redirect: got req %0b addr %h expected 1 fffffffc", imem_req_o, imem_addr_o); end
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (gnt_log.size() < 2 || gnt_log[0] !== 32'hFFFF_FFFC || gnt_log[1] !== 32'h0) begin
      errors++;
      $display("FAIL wrap_addr: got %h %h expected fffffffc 00000000",
               (gnt_log.size() > 0) ? gnt_log[0] : 32'hX, (gnt_log.size() > 1) ? gnt_log[1] : 32'hX);
    end
    checks++;
    if (got_pc.size() < 2 || got_pc[0] !== 32'hFFFF_FFFC || got_pc4[0] !== 32'h0 || got_pc[1] !== 32'h0) begin
      errors++;
      $display("FAIL wrap_pc: got pc %h pc4 %h next %h expected fffffffc 00000000 00000000",
               (got_pc.size() > 0) ? got_pc[0] : 32'hX, (got_pc4.size() > 0) ? got_pc4[0] : 32'hX,
               (got_pc.size() > 1) ? got_pc[1] : 32'hX);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0; inst_ready_i = 1'b0;
    lat = 1; gnt_delay = 0; delay_addr = 32'hFFFF_FFFF;
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_gnt_delay();
    test_redirect_flush();
    test_redirect_handshake();
    test_misaligned_and_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
